// File: rtl/conv_operand_feeder_pkg.sv
// conv_operand_feeder_pkg
// Shared types and helpers for the convolution operand feeder:
//   - feed_state_e : feeder FSM states
//   - loop_cnt_t   : 32-bit loop counter type used for every loop index
//   - pad_of()     : border padding for an odd square kernel (K/2)
// Optional build macro used by the feeder files: CONV_FEEDER_ZERO_PAD_EN.

package conv_operand_feeder_pkg;

    typedef enum logic [2:0] {
        FEED_IDLE,
        FEED_READ_A,
        FEED_PRESENT_A,
        FEED_READ_B,
        FEED_PRESENT_B
    } feed_state_e;

    typedef logic [31:0] loop_cnt_t;

    function automatic int pad_of(input int kernel_size);
        return kernel_size / 2;
    endfunction

endpackage

// File: rtl/conv_operand_feeder_addr_gen.sv
// conv_addr_gen
// Combinational coordinate and border logic for the operand feeder.
// Ports:
//   x, y, ch_in, ch_out, k_v, k_h : loop counters selecting one tap
//   act_addr : activation SRAM address (truncated to ACT_ADDR_WIDTH)
//   wgt_addr : weight SRAM address (truncated to WGT_ADDR_WIDTH)
//   oob      : tap lies outside the feature map (only with CONV_FEEDER_ZERO_PAD_EN)
// Build macro: CONV_FEEDER_ZERO_PAD_EN defined -> zero padding (oob reported);
// undefined -> coordinates clamped to the map (edge replicate), no oob port.

module conv_addr_gen
    import conv_operand_feeder_pkg::*;
#(
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int INPUT_NB_CHANNELS  = 64,
    parameter int KERNEL_SIZE        = 3,
    parameter int ACT_ADDR_WIDTH     = 26,
    parameter int WGT_ADDR_WIDTH     = 16
) (
    input  loop_cnt_t                 x,
    input  loop_cnt_t                 y,
    input  loop_cnt_t                 ch_in,
    input  loop_cnt_t                 ch_out,
    input  loop_cnt_t                 k_v,
    input  loop_cnt_t                 k_h,
    output logic [ACT_ADDR_WIDTH-1:0] act_addr,
    output logic [WGT_ADDR_WIDTH-1:0] wgt_addr
`ifdef CONV_FEEDER_ZERO_PAD_EN
    ,
    output logic                      oob
`endif
);

    localparam logic signed [31:0] PAD   = 32'(pad_of(KERNEL_SIZE));
    localparam logic signed [31:0] W_S   = 32'(FEATURE_MAP_WIDTH);
    localparam logic signed [31:0] H_S   = 32'(FEATURE_MAP_HEIGHT);
    localparam logic signed [31:0] CIN_S = 32'(INPUT_NB_CHANNELS);
    localparam logic signed [31:0] K_S   = 32'(KERNEL_SIZE);

    logic signed [31:0] ix;
    logic signed [31:0] iy;
    logic signed [31:0] ix_use;
    logic signed [31:0] iy_use;
    logic signed [31:0] act_full;
    logic signed [31:0] wgt_full;

    always_comb begin
        ix = $signed(x) + $signed(k_h) - PAD;
        iy = $signed(y) + $signed(k_v) - PAD;
`ifdef CONV_FEEDER_ZERO_PAD_EN
        // Out-of-range taps keep their raw coordinates; the address is
        // meaningless for them but no read is issued.
        oob    = (ix < 0) || (ix >= W_S) || (iy < 0) || (iy >= H_S);
        ix_use = ix;
        iy_use = iy;
`else
        // Edge replicate: clamp into the map so every tap is a real read.
        ix_use = (ix < 0) ? 32'sd0 : ((ix >= W_S) ? W_S - 32'sd1 : ix);
        iy_use = (iy < 0) ? 32'sd0 : ((iy >= H_S) ? H_S - 32'sd1 : iy);
`endif
        act_full = (iy_use * W_S + ix_use) * CIN_S + $signed(ch_in);
        wgt_full = (($signed(ch_out) * CIN_S + $signed(ch_in)) * K_S + $signed(k_v)) * K_S
                   + $signed(k_h);
        act_addr = act_full[ACT_ADDR_WIDTH-1:0];
        wgt_addr = wgt_full[WGT_ADDR_WIDTH-1:0];
    end

endmodule

// File: rtl/conv_operand_feeder.sv
// conv_operand_feeder
// Streams activation (a) and weight (b) operands to the convolution MAC
// controller in loop order x, y, ch_in, ch_out, k_v, k_h (k_h innermost),
// one full layer per start.
// Ports:
//   clk, arst_n_in         : clock, asynchronous active-low reset
//   start / busy / done    : layer launch, running flag, end-of-layer pulse
//   act_re/act_addr/act_rdata : activation SRAM read port (1-cycle latency)
//   wgt_re/wgt_addr/wgt_rdata : weight SRAM read port (1-cycle latency)
//   a_data/a_valid/a_ready : activation operand handshake
//   b_data/b_valid/b_ready : weight operand handshake
// Build macro: CONV_FEEDER_ZERO_PAD_EN (defined: zero padding at borders,
// undefined: edge-replicate clamping with a read on every tap).

module conv_operand_feeder
    import conv_operand_feeder_pkg::*;
#(
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int INPUT_NB_CHANNELS  = 64,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int KERNEL_SIZE        = 3,
    parameter int DATA_WIDTH         = 16,
    parameter int ACT_ADDR_WIDTH     = 26,
    parameter int WGT_ADDR_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      arst_n_in,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      act_re,
    output logic [ACT_ADDR_WIDTH-1:0] act_addr,
    input  logic [DATA_WIDTH-1:0]     act_rdata,
    output logic                      wgt_re,
    output logic [WGT_ADDR_WIDTH-1:0] wgt_addr,
    input  logic [DATA_WIDTH-1:0]     wgt_rdata,
    output logic [DATA_WIDTH-1:0]     a_data,
    output logic                      a_valid,
    input  logic                      a_ready,
    output logic [DATA_WIDTH-1:0]     b_data,
    output logic                      b_valid,
    input  logic                      b_ready
);

    localparam loop_cnt_t X_LAST  = loop_cnt_t'(FEATURE_MAP_WIDTH - 1);
    localparam loop_cnt_t Y_LAST  = loop_cnt_t'(FEATURE_MAP_HEIGHT - 1);
    localparam loop_cnt_t CI_LAST = loop_cnt_t'(INPUT_NB_CHANNELS - 1);
    localparam loop_cnt_t CO_LAST = loop_cnt_t'(OUTPUT_NB_CHANNELS - 1);
    localparam loop_cnt_t K_LAST  = loop_cnt_t'(KERNEL_SIZE - 1);

    feed_state_e state;

    loop_cnt_t x, y, ch_in, ch_out, k_v, k_h;
    loop_cnt_t x_n, y_n, ch_in_n, ch_out_n, k_v_n, k_h_n;
    loop_cnt_t x_s, y_s, ch_in_s, ch_out_s, k_v_s, k_h_s;
    logic      c_kv, c_co, c_ci, c_y, c_x, all_last;

    logic [ACT_ADDR_WIDTH-1:0] gen_act_addr;
    logic [WGT_ADDR_WIDTH-1:0] gen_wgt_addr;
    logic                      a_re_nx;

    // Next-tap counters: a ripple of carries from k_h outwards.
    always_comb begin
        c_kv     = (k_h == K_LAST);
        c_co     = c_kv && (k_v == K_LAST);
        c_ci     = c_co && (ch_out == CO_LAST);
        c_y      = c_ci && (ch_in == CI_LAST);
        c_x      = c_y && (y == Y_LAST);
        all_last = c_x && (x == X_LAST);

        k_h_n    = c_kv ? '0 : k_h + 1;
        k_v_n    = c_kv ? ((k_v == K_LAST) ? '0 : k_v + 1) : k_v;
        ch_out_n = c_co ? ((ch_out == CO_LAST) ? '0 : ch_out + 1) : ch_out;
        ch_in_n  = c_ci ? ((ch_in == CI_LAST) ? '0 : ch_in + 1) : ch_in;
        y_n      = c_y ? ((y == Y_LAST) ? '0 : y + 1) : y;
        x_n      = c_x ? ((x == X_LAST) ? '0 : x + 1) : x;

        // In PRESENT_B the registered read address must belong to the tap
        // that follows the pending b handshake, so look one tap ahead there.
        if (state == FEED_PRESENT_B) begin
            x_s = x_n; y_s = y_n; ch_in_s = ch_in_n;
            ch_out_s = ch_out_n; k_v_s = k_v_n; k_h_s = k_h_n;
        end else begin
            x_s = x; y_s = y; ch_in_s = ch_in;
            ch_out_s = ch_out; k_v_s = k_v; k_h_s = k_h;
        end
    end

`ifdef CONV_FEEDER_ZERO_PAD_EN
    logic gen_oob;
    logic oob_q;
    assign a_re_nx = !gen_oob;
`else
    assign a_re_nx = 1'b1;
`endif

    conv_addr_gen #(
        .FEATURE_MAP_WIDTH (FEATURE_MAP_WIDTH),
        .FEATURE_MAP_HEIGHT(FEATURE_MAP_HEIGHT),
        .INPUT_NB_CHANNELS (INPUT_NB_CHANNELS),
        .KERNEL_SIZE       (KERNEL_SIZE),
        .ACT_ADDR_WIDTH    (ACT_ADDR_WIDTH),
        .WGT_ADDR_WIDTH    (WGT_ADDR_WIDTH)
    ) u_addr_gen (
        .x       (x_s),
        .y       (y_s),
        .ch_in   (ch_in_s),
        .ch_out  (ch_out_s),
        .k_v     (k_v_s),
        .k_h     (k_h_s),
        .act_addr(gen_act_addr),
        .wgt_addr(gen_wgt_addr)
`ifdef CONV_FEEDER_ZERO_PAD_EN
        ,
        .oob     (gen_oob)
`endif
    );

    // SRAM read data is held between reads, so gating on valid keeps the
    // operands stable across stalls and zero outside a presentation.
`ifdef CONV_FEEDER_ZERO_PAD_EN
    assign a_data = (a_valid && !oob_q) ? act_rdata : '0;
`else
    assign a_data = a_valid ? act_rdata : '0;
`endif
    assign b_data = b_valid ? wgt_rdata : '0;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state    <= FEED_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            act_re   <= 1'b0;
            wgt_re   <= 1'b0;
            a_valid  <= 1'b0;
            b_valid  <= 1'b0;
            act_addr <= '0;
            wgt_addr <= '0;
`ifdef CONV_FEEDER_ZERO_PAD_EN
            oob_q    <= 1'b0;
`endif
            x <= '0; y <= '0; ch_in <= '0; ch_out <= '0; k_v <= '0; k_h <= '0;
        end else begin
            done   <= 1'b0;
            act_re <= 1'b0;
            wgt_re <= 1'b0;
            case (state)
                FEED_IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done) begin
                        state    <= FEED_READ_A;
                        busy     <= 1'b1;
                        act_re   <= a_re_nx;
                        act_addr <= gen_act_addr;
`ifdef CONV_FEEDER_ZERO_PAD_EN
                        oob_q    <= gen_oob;
`endif
                    end
                end
                FEED_READ_A: begin
                    state   <= FEED_PRESENT_A;
                    a_valid <= 1'b1;
                end
                FEED_PRESENT_A: begin
                    if (a_ready) begin
                        state    <= FEED_READ_B;
                        a_valid  <= 1'b0;
                        wgt_re   <= 1'b1;
                        wgt_addr <= gen_wgt_addr;
                    end
                end
                FEED_READ_B: begin
                    state   <= FEED_PRESENT_B;
                    b_valid <= 1'b1;
                end
                FEED_PRESENT_B: begin
                    if (b_ready) begin
                        b_valid <= 1'b0;
                        x <= x_n; y <= y_n; ch_in <= ch_in_n;
                        ch_out <= ch_out_n; k_v <= k_v_n; k_h <= k_h_n;
                        if (all_last) begin
                            state <= FEED_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= FEED_READ_A;
                            act_re   <= a_re_nx;
                            act_addr <= gen_act_addr;
`ifdef CONV_FEEDER_ZERO_PAD_EN
                            oob_q    <= gen_oob;
`endif
                        end
                    end
                end
                default: state <= FEED_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_operand_feeder.sv
// Bench for conv_operand_feeder on a 4x4x2x2 layer with a 3x3 kernel.
// Memories: act[a] = a, wgt[w] = w + 100, both with 1-cycle read latency.

module tb_conv_operand_feeder;

    localparam int W = 4, H = 4, CIN = 2, COUT = 2, K = 3, PAD = 1;
    localparam int DW = 16, AAW = 26, WAW = 16;
    localparam int NTAPS = W * H * CIN * COUT * K * K;

    logic           clk = 1'b0;
    logic           arst_n_in = 1'b0;
    logic           start = 1'b0;
    logic           busy, done;
    logic           act_re, wgt_re;
    logic [AAW-1:0] act_addr;
    logic [WAW-1:0] wgt_addr;
    logic [DW-1:0]  act_rdata, wgt_rdata;
    logic [DW-1:0]  a_data, b_data;
    logic           a_valid, b_valid;
    logic           a_ready = 1'b0, b_ready = 1'b0;

    always #5 clk = ~clk;

    conv_operand_feeder #(
        .FEATURE_MAP_WIDTH (W),
        .FEATURE_MAP_HEIGHT(H),
        .INPUT_NB_CHANNELS (CIN),
        .OUTPUT_NB_CHANNELS(COUT),
        .KERNEL_SIZE       (K),
        .DATA_WIDTH        (DW),
        .ACT_ADDR_WIDTH    (AAW),
        .WGT_ADDR_WIDTH    (WAW)
    ) dut (
        .clk      (clk),
        .arst_n_in(arst_n_in),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .act_re   (act_re),
        .act_addr (act_addr),
        .act_rdata(act_rdata),
        .wgt_re   (wgt_re),
        .wgt_addr (wgt_addr),
        .wgt_rdata(wgt_rdata),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
    );

    // Memory models: data appears one cycle after the read and is held.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            act_rdata <= '0;
            wgt_rdata <= '0;
        end else begin
            if (act_re) act_rdata <= act_addr[DW-1:0];
            if (wgt_re) wgt_rdata <= DW'(wgt_addr) + DW'(100);
        end
    end

    typedef struct {
        logic [31:0] a;
        logic        re;
        logic [31:0] aaddr;
        logic [31:0] b;
        logic [31:0] waddr;
    } tap_t;

    tap_t qa[$];
    tap_t qb[$];

    int total = 0;
    int bad = 0;
    int na = 0, nb = 0, done_cnt = 0;
    bit mon_en = 0, spec_chk = 0;
    bit rd_seen = 0, a_stall = 0, b_stall = 0;
    logic [31:0] rd_addr = 0;
    logic [DW-1:0] a_hold = 0, b_hold = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Push the expected operand stream for one layer.
    task automatic load_expected();
        tap_t t;
        int ix, iy;
        bit oob;
        qa.delete();
        qb.delete();
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                for (int ci = 0; ci < CIN; ci++)
                    for (int co = 0; co < COUT; co++)
                        for (int kv = 0; kv < K; kv++)
                            for (int kh = 0; kh < K; kh++) begin
                                ix = x + kh - PAD;
                                iy = y + kv - PAD;
                                oob = (ix < 0) || (ix >= W) || (iy < 0) || (iy >= H);
`ifdef CONV_FEEDER_ZERO_PAD_EN
                                t.re = !oob;
`else
                                if (ix < 0) ix = 0;
                                if (ix >= W) ix = W - 1;
                                if (iy < 0) iy = 0;
                                if (iy >= H) iy = H - 1;
                                t.re = 1'b1;
`endif
                                t.aaddr = 32'((iy * W + ix) * CIN + ci);
                                t.a = t.re ? t.aaddr : 32'd0;
                                t.waddr = 32'(((co * CIN + ci) * K + kv) * K + kh);
                                t.b = t.waddr + 32'd100;
                                qa.push_back(t);
                                qb.push_back(t);
                            end
    endtask

    // Monitor: samples on the falling edge, handshakes complete on the next rising edge.
    initial begin
        tap_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (done) done_cnt++;
                if (act_re) begin
                    rd_seen = 1;
                    rd_addr = 32'(act_addr);
                end
                if (a_valid) begin
                    if (a_stall) chk("a_stable", a_data, a_hold);
                    a_hold  = a_data;
                    a_stall = !a_ready;
                    if (a_ready) begin
                        if (qa.size() == 0) chk("a_extra", 1, 0);
                        else begin
                            e = qa.pop_front();
                            chk("a_data", a_data, e.a);
                            chk("a_re", rd_seen, e.re);
                            if (e.re) chk("a_addr", rd_addr, e.aaddr);
                            if (spec_chk) begin
`ifdef CONV_FEEDER_ZERO_PAD_EN
                                if (na == 0) chk("a0_re", rd_seen, 0);
`else
                                if (na == 0) chk("a0_re", rd_seen, 1);
                                if (na == 2) chk("a2_data", a_data, 2);
                                if (na == 2) chk("a2_addr", rd_addr, 2);
`endif
                                if (na == 0) chk("a0_data", a_data, 0);
                                if (na == 4) chk("a4_data", a_data, 0);
                                if (na == 198) chk("a198_addr", rd_addr, 1);
                                if (na == 198) chk("a198_data", a_data, 1);
                            end
                        end
                        rd_seen = 0;
                        na++;
                    end
                end else a_stall = 0;
                if (b_valid) begin
                    if (b_stall) chk("b_stable", b_data, b_hold);
                    b_hold  = b_data;
                    b_stall = !b_ready;
                    if (b_ready) begin
                        if (qb.size() == 0) chk("b_extra", 1, 0);
                        else begin
                            e = qb.pop_front();
                            chk("b_data", b_data, e.b);
                            chk("w_addr", wgt_addr, e.waddr);
                            if (spec_chk) begin
                                if (nb == 0) chk("b0_data", b_data, 100);
                                if (nb == 4) chk("b4_data", b_data, 104);
                                if (nb == 198) chk("b198_addr", wgt_addr, 9);
                                if (nb == 198) chk("b198_data", b_data, 109);
                            end
                        end
                        nb++;
                    end
                end else b_stall = 0;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_act_re"}, act_re, 0);
        chk({tag, "_wgt_re"}, wgt_re, 0);
        chk({tag, "_a_valid"}, a_valid, 0);
        chk({tag, "_b_valid"}, b_valid, 0);
        chk({tag, "_act_addr"}, act_addr, 0);
        chk({tag, "_wgt_addr"}, wgt_addr, 0);
        chk({tag, "_a_data"}, a_data, 0);
        chk({tag, "_b_data"}, b_data, 0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Runs until done is seen (optionally randomising ready), bounded.
    task automatic wait_done(input bit rnd, input string tag);
        bit seen = 0;
        for (int i = 0; i < 30000 && !seen; i++) begin
            @(posedge clk); #1;
            if (rnd) begin
                a_ready = 1'($urandom_range(0, 1));
                b_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (done) seen = 1;
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_nb"}, nb, NTAPS);
    endtask

    task automatic arm_run();
        load_expected();
        na = 0; nb = 0;
        rd_seen = 0; a_stall = 0; b_stall = 0;
        mon_en = 1;
    endtask

    initial begin
        // Reset and idle
        repeat (3) @(posedge clk);
        #2 arst_n_in = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");

        // Run 1: ready tied high, start latency, start in done cycle
        a_ready = 1'b1; b_ready = 1'b1;
        arm_run();
        spec_chk = 1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("lat_busy_n1", busy, 1);
        chk("lat_avalid_n1", a_valid, 0);
        @(negedge clk);
        chk("lat_avalid_n2", a_valid, 1);
        wait_done(0, "run1");
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("done_start_busy", busy, 0);
            chk("done_start_avalid", a_valid, 0);
            chk("done_start_act_re", act_re, 0);
        end
        chk("run1_qa_left", qa.size(), 0);
        chk("run1_qb_left", qb.size(), 0);
        spec_chk = 0;

        // Run 2: random ready stalls
        arm_run();
        pulse_start();
        wait_done(1, "run2");
        chk("run2_qa_left", qa.size(), 0);
        chk("run2_qb_left", qb.size(), 0);
        a_ready = 1'b1; b_ready = 1'b1;

        // Run 3: reset mid-layer, then a clean restart
        arm_run();
        pulse_start();
        begin
            bit hit = 0;
            for (int i = 0; i < 5000 && !hit; i++) begin
                @(negedge clk); #1;
                if (nb >= 100) hit = 1;
            end
            chk("rst_reach_100", hit, 1);
        end
        mon_en = 0;
        arst_n_in = 1'b0;
        #1 check_idle_outputs("midrst");
        begin
            int dseen = 0;
            repeat (4) begin
                @(negedge clk);
                if (done) dseen++;
            end
            arst_n_in = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (done) dseen++;
            end
            chk("midrst_no_done", dseen, 0);
        end
        chk("midrst_done_cnt", done_cnt, 2);
        spec_chk = 1;
        arm_run();
        pulse_start();
        wait_done(0, "run3");
        chk("run3_qa_left", qa.size(), 0);
        chk("run3_qb_left", qb.size(), 0);
        @(negedge clk);
        chk("done_cnt", done_cnt, 3);
        chk("end_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
